// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state codes and the oversampling constants.
// Latency: none (constants and types only).
// Backpressure: none.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int S_W        = $clog2(OVERSAMPLE);

    // Sample counter positions: mid start bit, and mid-bit for every later bit.
    localparam logic [S_W-1:0] SAMPLE_MID = S_W'(7);
    localparam logic [S_W-1:0] SAMPLE_END = S_W'(15);

    // Receiver state type with fixed, legacy-compatible codes.
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t IDLE   = 3'd0;
    localparam rx_state_t START  = 3'd1;
    localparam rx_state_t DATA   = 3'd2;
    localparam rx_state_t PARITY = 3'd3;
    localparam rx_state_t STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received words, with occupancy count.
// Latency: a pushed word is visible at head_dat one cycle after the push edge.
// Backpressure: push into a full FIFO is dropped unless a pop occurs the same cycle; pop when empty is ignored.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointer arithmetic: one extra MSB distinguishes full from empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count    = wr_ptr_q - rd_ptr_q;
        head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised 16x-oversampling UART receiver with show-ahead RX FIFO and sticky error flags; UART_RX_PARITY_EN adds a parity bit.
// Latency: 2-cycle input sync; a word appears at rd_data one cycle after its stop-bit sample.
// Backpressure: none on the line; words arriving into a full FIFO are dropped and flagged as overrun.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_odd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rd_count,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_last;
    logic                 tick;
    rx_state_t            state_q, state_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 push, fe_set, ov_set, fifo_full;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        rx_s    = sync2_q;
    end

    // Tick generator. A frame only leaves IDLE on a tick, i.e. exactly at the
    // wrap, so the counter is already restarting at 0 when the frame begins.
    // A new baud_div is picked up at the next wrap comparison; a divisor of 0 acts as 1.
    always_comb begin
        div_last  = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
        tick      = (div_cnt_q >= div_last);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

`ifdef UART_RX_PARITY_EN
    logic par_pend_q, par_pend_d;
    logic exp_par;
    logic parity_err_q, parity_err_d;
`endif

    // Deframing FSM, advanced only on ticks; samples mid-bit, LSB first.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        fe_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_pend_d = par_pend_q;
        exp_par    = (^shreg_q) ^ parity_odd;
`endif
        case (state_q)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SAMPLE_MID) begin
                        s_d       = '0;
                        bit_cnt_d = '0;
                        // Line back high at mid start bit: a glitch, drop silently.
                        state_d   = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        par_pend_d = 1'b0;
`endif
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SAMPLE_END) begin
                        s_d       = '0;
                        shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == SAMPLE_END) begin
                        s_d        = '0;
                        par_pend_d = (rx_s != exp_par);
                        state_d    = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == SAMPLE_END) begin
                        s_d     = '0;
                        state_d = IDLE;
                        push    = rx_s;
                        fe_set  = !rx_s;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a same-cycle set beats err_clr. Overrun means the word was
    // dropped, which only happens when full and not being popped this cycle.
    always_comb begin
        ov_set      = push && fifo_full && !rd_en;
        frame_err_d = fe_set | (frame_err_q & ~err_clr);
        overrun_d   = ov_set | (overrun_q & ~err_clr);
    end

`ifdef UART_RX_PARITY_EN
    // Parity flag is raised when a word carrying a parity mismatch is accepted.
    always_comb begin
        parity_err_d = (push && par_pend_q) | (parity_err_q & ~err_clr);
    end

    // Parity bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_pend_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_pend_q   <= par_pend_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    // Receiver state registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_cnt_q   <= '0;
            state_q     <= IDLE;
            s_q         <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            s_q         <= s_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (shreg_q),
        .pop      (rd_en),
        .head_dat (rd_data),
        .empty    (rd_empty),
        .full     (fifo_full),
        .count    (rd_count)
    );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: serial frames in, FIFO contents and sticky flags checked against a queue model.
// Latency: frames are checked once the line has been idle long enough for the word to settle.
// Backpressure: the bench pops and clears at chosen points, including the exact push cycle.
module tb_uart_rx_param;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int DIV_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             rx = 1'b1;
    logic [DIV_W-1:0] baud_div = 16'd4;
    logic             parity_odd = 1'b0;
    logic             rd_en = 1'b0;
    logic             err_clr = 1'b0;
    logic [DB-1:0]    rd_data;
    logic             rd_empty;
    logic [CW-1:0]    rd_count;
    logic             frame_err, overrun, parity_err;

    uart_rx_param #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_div(baud_div), .parity_odd(parity_odd),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_count(rd_count),
        .err_clr(err_clr), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;

    // Reference model: expected FIFO contents and sticky flags.
    logic [DB-1:0] exp_q[$];
    bit exp_fe = 0, exp_ov = 0, exp_pe = 0;
    bit chk_en = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model while the line is settled.
    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("cyc_empty", 32'(rd_empty), 32'(exp_q.size() == 0));
            check("cyc_count", 32'(rd_count), 32'(exp_q.size()));
            if (exp_q.size() != 0) check("cyc_head", 32'(rd_data), 32'(exp_q[0]));
            check("cyc_frame_err", 32'(frame_err), 32'(exp_fe));
            check("cyc_overrun", 32'(overrun), 32'(exp_ov));
            check("cyc_parity_err", 32'(parity_err), 32'(exp_pe));
        end
    end

    task automatic model_frame(input logic [DB-1:0] w, input bit stop_ok, input bit par_ok,
                               input bit pop_same, input bit clr_same);
        if (clr_same) begin exp_fe = 0; exp_ov = 0; exp_pe = 0; end
        if (pop_same && exp_q.size() != 0) exp_q.delete(0);
        if (!stop_ok) exp_fe = 1;
        else begin
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else                      exp_ov = 1;
            if (!par_ok) exp_pe = 1;
        end
    endtask

    task automatic apply_reset(input logic [DIV_W-1:0] dv);
        chk_en = 0;
        @(negedge clk);
        reset = 0; baud_div = dv; rx = 1; rd_en = 0; err_clr = 0;
        #2;
        check("rst_empty", 32'(rd_empty), 32'd1);
        check("rst_count", 32'(rd_count), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        exp_q.delete(); exp_fe = 0; exp_ov = 0; exp_pe = 0;
        @(negedge clk);
        reset = 1;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
    endtask

    function automatic int eff_div();
        return (baud_div == '0) ? 1 : int'(baud_div);
    endfunction

    // Move to just after an edge where a baud tick lands (tick every dv cycles from reset).
    task automatic align(input int dv);
        @(posedge clk); #1;
        for (int k = 0; k < dv && (cyc % dv) != 0; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int dv);
        rx = b;
        repeat (16 * dv) @(posedge clk);
        #1;
    endtask

    // strobe: 0 none, 1 rd_en, 2 err_clr, asserted in the stop-sample (push) cycle.
    task automatic send_frame(input logic [DB-1:0] w, input logic stop_bit, input bit par_flip, input int strobe);
        int dv, d0, p_edge;
        logic pbit;
        dv = eff_div();
        chk_en = 0;
        // Parity bit making the total count of ones match the selected sense.
        pbit = logic'((($countones(w) + int'(parity_odd)) % 2) != 0) ^ par_flip;
        if (strobe != 0) align(dv);
        // Start edge is seen 3 cycles later at the earliest, on the next tick;
        // then 8 ticks to mid start bit and 16 ticks per following bit.
        d0 = dv * ((3 + dv - 1) / dv);
        p_edge = d0 + 8 * dv + 16 * dv * (DB + PB + 1);
        fork
            begin
                drive_bit(1'b0, dv);
                for (int i = 0; i < DB; i++) drive_bit(w[i], dv);
                if (PB != 0) drive_bit(pbit, dv);
                drive_bit(stop_bit, dv);
                rx = 1'b1;
            end
            begin
                if (strobe != 0) begin
                    repeat (p_edge - 1) @(posedge clk);
                    #1;
                    if (strobe == 1) rd_en = 1; else err_clr = 1;
                    @(posedge clk);
                    #1 rd_en = 0; err_clr = 0;
                end
            end
        join
        repeat (16 * dv + 4) @(posedge clk);
        #1;
        model_frame(w, stop_bit, (PB == 0) || !par_flip, strobe == 1, strobe == 2);
        chk_en = 1;
    endtask

    task automatic do_pop();
        @(negedge clk);
        rd_en = 1;
        @(posedge clk);
        #1 rd_en = 0;
        if (exp_q.size() != 0) exp_q.delete(0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        err_clr = 1;
        @(posedge clk);
        #1 err_clr = 0;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
    endtask

    logic [DB-1:0] t4w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [DB-1:0] t5w [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        apply_reset(16'd4);

        // Single good frame, then pop it.
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        check("t1_empty", 32'(rd_empty), 32'd0);
        check("t1_data", 32'(rd_data), 32'hA5);
        check("t1_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        do_pop();
        check("t1_empty_after_pop", 32'(rd_empty), 32'd1);
        check("t1_count_after_pop", 32'(rd_count), 32'd0);

        // Pop on an empty FIFO is ignored.
        do_pop();
        check("empty_pop_count", 32'(rd_count), 32'd0);

        // Short low glitch on an idle line.
        chk_en = 0;
        rx = 0;
        repeat (3 * 4) @(posedge clk);
        #1 rx = 1;
        repeat (16 * 4 * 2) @(posedge clk);
        #1 chk_en = 1;
        check("t2_empty", 32'(rd_empty), 32'd1);
        check("t2_flags", {29'd0, frame_err, overrun, parity_err}, 32'd0);

        // Bad stop bit, clear, then a set coinciding with err_clr.
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check("t3_frame_err", 32'(frame_err), 32'd1);
        check("t3_empty", 32'(rd_empty), 32'd1);
        do_clear();
        check("t3_cleared", 32'(frame_err), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b0, 2);
        check("t3_set_beats_clr", 32'(frame_err), 32'd1);
        do_clear();

        // Overrun: five words into a four-deep FIFO.
        for (int i = 0; i < 5; i++) send_frame(t4w[i], 1'b1, 1'b0, 0);
        check("t4_count", 32'(rd_count), 32'd4);
        check("t4_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t4_word", 32'(rd_data), 32'(t4w[i]));
            do_pop();
        end
        do_clear();

        // Full FIFO with a pop in the push cycle: no overrun.
        for (int i = 0; i < 4; i++) send_frame(t5w[i], 1'b1, 1'b0, 0);
        send_frame(t5w[4], 1'b1, 1'b0, 1);
        check("t5_count", 32'(rd_count), 32'd4);
        check("t5_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 5; i++) begin
            check("t5_word", 32'(rd_data), 32'(t5w[i]));
            do_pop();
        end

`ifdef UART_RX_PARITY_EN
        parity_odd = 0;
        send_frame(8'h07, 1'b1, 1'b1, 0);
        check("t6_data", 32'(rd_data), 32'h07);
        check("t6_parity_err", 32'(parity_err), 32'd1);
        do_clear();
        send_frame(8'h07, 1'b1, 1'b0, 0);
        check("t6_parity_ok", 32'(parity_err), 32'd0);
        do_pop();
        do_pop();
`endif

        // Reset in the middle of a frame with data and flags present.
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        send_frame(8'h00, 1'b0, 1'b0, 0);
        chk_en = 0;
        rx = 0;
        repeat (40) @(posedge clk);
        apply_reset(16'd2);

        // Randomised rounds, each with its own divisor (0 included) and parity sense.
        for (int r = 0; r < 4; r++) begin
            apply_reset(DIV_W'($urandom_range(0, 5)));
            parity_odd = logic'($urandom_range(0, 1));
            for (int f = 0; f < 7; f++) begin
                logic [DB-1:0] w;
                bit stop_ok, pf;
                w = DB'($urandom);
                stop_ok = ($urandom_range(0, 4) != 0);
                pf = (PB != 0) && ($urandom_range(0, 3) == 0);
                send_frame(w, stop_ok, pf, 0);
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) do_pop();
                if ($urandom_range(0, 5) == 0) do_clear();
            end
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
